// File: rtl/wb_cam_fifo_if.sv
// rtl/wb_cam_fifo_if.sv - Wishbone slave bus bundle for the camera FIFO
interface wb_cam_fifo_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_sel_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_cam_fifo.sv
// rtl/wb_cam_fifo.sv - camera frame capture, pixel packer and word FIFO behind a Wishbone slave
module wb_cam_fifo #(
  parameter int wb_dat_width = 32,
  parameter int wb_adr_width = 32,
  parameter int CAM_W        = 8,
  parameter int PACK         = 4,
  parameter int FIFO_AW      = 4,
  parameter int XCLK_DIV     = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             o_xclk,
  input  logic             i_pclk,
  input  logic             i_href,
  input  logic             i_vsyn,
  input  logic [CAM_W-1:0] i_data,
  output logic             o_pwdn,
  output logic             o_reset,
  wb_cam_fifo_if.slave     wb
);
  localparam int DW    = wb_dat_width;
  localparam int AW    = wb_adr_width;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LVW   = FIFO_AW + 1;
  localparam int LW    = ($clog2(PACK) > 0) ? $clog2(PACK) : 1;
  localparam int XW    = ($clog2(XCLK_DIV) > 0) ? $clog2(XCLK_DIV) : 1;
  localparam int PW    = PACK * CAM_W;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPT} state_t;

  state_t r_state, w_state_nxt;
  logic [1:0] r_pclk_s, r_href_s, r_vsyn_s;
  logic r_pclk_d, r_vsyn_d;
  logic [CAM_W-1:0] r_data_s0, r_data_s1;
  logic [XW-1:0] r_xcnt;
  logic r_xclk, r_ack, r_ovf, r_udf, r_done;
  logic [4:0] r_ctrl;
  logic [DW-1:0] r_dat_o, r_count;
  logic [PW-1:0] r_pack, w_pack_next;
  logic [LW-1:0] r_lane;
  logic [DW-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [LVW-1:0] r_level;

  logic w_pclk_rise, w_vsyn_rise, w_vsyn_fall;
  logic w_req, w_acc, w_rd, w_wr, w_ctrl_wr, w_start, w_flush;
  logic [1:0] w_adr;
  logic w_empty, w_full, w_pop, w_push, w_wr_en, w_ovf_set;
  logic w_busy, w_capt, w_arm, w_frame_end, w_sample, w_idle_start;
  logic [DW-1:0] w_push_word, w_status, w_rdata;
  logic w_unused;

  assign w_unused = ^{wb.wb_sel_i, wb.wb_adr_i[AW-1:4], wb.wb_adr_i[1:0], wb.wb_dat_i[DW-1:5]};

  // Camera inputs are asynchronous; data rides the same two-stage pipeline as Pclk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pclk_s  <= '0;
      r_href_s  <= '0;
      r_vsyn_s  <= '0;
      r_pclk_d  <= 1'b0;
      r_vsyn_d  <= 1'b0;
      r_data_s0 <= '0;
      r_data_s1 <= '0;
    end else begin
      r_pclk_s  <= {r_pclk_s[0], i_pclk};
      r_href_s  <= {r_href_s[0], i_href};
      r_vsyn_s  <= {r_vsyn_s[0], i_vsyn};
      r_pclk_d  <= r_pclk_s[1];
      r_vsyn_d  <= r_vsyn_s[1];
      r_data_s0 <= i_data;
      r_data_s1 <= r_data_s0;
    end
  end

  assign w_pclk_rise = r_pclk_s[1] & ~r_pclk_d;
  assign w_vsyn_rise = r_vsyn_s[1] & ~r_vsyn_d;
  assign w_vsyn_fall = ~r_vsyn_s[1] & r_vsyn_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xcnt <= '0;
      r_xclk <= 1'b0;
    end else if (r_xcnt == XW'(XCLK_DIV - 1)) begin
      r_xcnt <= '0;
      r_xclk <= ~r_xclk;
    end else begin
      r_xcnt <= r_xcnt + XW'(1);
    end
  end

  assign o_xclk  = r_xclk;
  assign o_pwdn  = r_ctrl[3];
  assign o_reset = r_ctrl[4];

  // Every access takes the request cycle plus one ack cycle; side effects fire only in the first.
  assign w_req     = wb.wb_stb_i & wb.wb_cyc_i;
  assign w_acc     = w_req & ~r_ack;
  assign w_adr     = wb.wb_adr_i[3:2];
  assign w_rd      = w_acc & ~wb.wb_we_i;
  assign w_wr      = w_acc & wb.wb_we_i;
  assign w_ctrl_wr = w_wr & (w_adr == 2'd2);
  assign w_start   = w_ctrl_wr & wb.wb_dat_i[0];
  assign w_flush   = w_ctrl_wr & wb.wb_dat_i[2];
  assign wb.wb_ack_o = w_req & r_ack;
  assign wb.wb_dat_o = r_dat_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_ARM;
      S_ARM:   if (w_vsyn_fall) w_state_nxt = S_CAPT;
      S_CAPT:  if (w_vsyn_rise) w_state_nxt = r_ctrl[1] ? S_ARM : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy       = (r_state != S_IDLE);
    w_capt       = (r_state == S_CAPT);
    w_arm        = (r_state == S_ARM);
    w_idle_start = (r_state == S_IDLE) & w_start;
    w_frame_end  = w_capt & w_vsyn_rise;
    w_sample     = w_capt & ~w_vsyn_rise & w_pclk_rise & r_href_s[1];
  end

  // A full word includes the byte arriving this cycle; a frame-end flush only holds earlier lanes.
  always_comb begin
    w_pack_next = r_pack;
    for (int i = 0; i < PACK; i++)
      if (r_lane == LW'(i)) w_pack_next[i*CAM_W +: CAM_W] = r_data_s1;
    w_push      = 1'b0;
    w_push_word = '0;
    if (w_sample && r_lane == LW'(PACK - 1)) begin
      w_push      = 1'b1;
      w_push_word = DW'(w_pack_next);
    end else if (w_frame_end && r_lane != '0) begin
      w_push      = 1'b1;
      w_push_word = DW'(r_pack);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pack <= '0;
      r_lane <= '0;
    end else if (w_flush || w_idle_start || w_frame_end) begin
      r_pack <= '0;
      r_lane <= '0;
    end else if (w_sample) begin
      if (r_lane == LW'(PACK - 1)) begin
        r_pack <= '0;
        r_lane <= '0;
      end else begin
        r_pack <= w_pack_next;
        r_lane <= r_lane + LW'(1);
      end
    end
  end

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LVW'(DEPTH));
  assign w_pop     = w_rd & (w_adr == 2'd0) & ~w_empty;
  assign w_wr_en   = w_push & ~w_flush & (~w_full | w_pop);
  assign w_ovf_set = w_push & ~w_flush & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr] <= w_push_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)   r_rptr <= r_rptr + FIFO_AW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + LVW'(1);
        2'b01:   r_level <= r_level - LVW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_ctrl  <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= w_acc;
      if (w_flush)        r_ovf <= 1'b0;
      else if (w_ovf_set) r_ovf <= 1'b1;
      if (w_flush)                                 r_udf <= 1'b0;
      else if (w_rd && w_adr == 2'd0 && w_empty)   r_udf <= 1'b1;
      if (w_idle_start)     r_done <= 1'b0;
      else if (w_frame_end) r_done <= 1'b1;
      // Dropped words still count, so COUNT exposes how much of the frame was lost.
      if (w_idle_start || (w_arm && w_vsyn_fall)) r_count <= '0;
      else if (w_push && !w_flush && r_count != '1) r_count <= r_count + DW'(1);
      if (w_ctrl_wr) r_ctrl <= {wb.wb_dat_i[4], wb.wb_dat_i[3], 1'b0, wb.wb_dat_i[1], 1'b0};
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[FIFO_AW:0]     = r_level;
    w_status[16]            = w_empty;
    w_status[17]            = w_full;
    w_status[18]            = r_ovf;
    w_status[19]            = r_udf;
    w_status[20]            = r_done;
    w_status[21]            = w_busy;
    case (w_adr)
      2'd0:    w_rdata = w_empty ? '0 : r_mem[r_rptr];
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata = DW'(r_ctrl);
      default: w_rdata = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_dat_o <= '0;
    else if (w_rd) r_dat_o <= w_rdata;
  end
endmodule

// File: tb/tb_wb_cam_fifo.sv
// tb/tb_wb_cam_fifo.sv - directed self-checking bench for wb_cam_fifo
module tb_wb_cam_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pclk = 1'b0, href = 1'b0, vsyn = 1'b1;
  logic [7:0] cdata = 8'h00;
  logic xclk, pwdn, creset;
  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  wb_cam_fifo_if #(.DW(32), .AW(32)) wb ();

  wb_cam_fifo #(
    .wb_dat_width(32), .wb_adr_width(32), .CAM_W(8),
    .PACK(4), .FIFO_AW(4), .XCLK_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .o_xclk(xclk),
    .i_pclk(pclk), .i_href(href), .i_vsyn(vsyn), .i_data(cdata),
    .o_pwdn(pwdn), .o_reset(creset), .wb(wb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic [1:0] r, input logic we, input logic [31:0] wd,
                         output logic [31:0] rd);
    @(posedge clk); #1;
    wb.wb_adr_i = {28'd0, r, 2'b00};
    wb.wb_we_i  = we;
    wb.wb_dat_i = wd;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, wb.wb_ack_o}, 32'd1);
    rd = wb.wb_dat_o;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] r, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    wb_xfer(r, 1'b0, 32'd0, v);
    chk(tag, v, exp);
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] v;
    wb_xfer(r, 1'b1, d, v);
  endtask

  task automatic cam_byte(input logic [7:0] b);
    cdata = b;
    #40 pclk = 1'b1;
    #40 pclk = 1'b0;
  endtask

  task automatic cam_line(input logic [7:0] first, input int n);
    href = 1'b1;
    #40;
    for (int i = 0; i < n; i++) cam_byte(first + 8'(i));
    #40 href = 1'b0;
    #200;
  endtask

  task automatic frame_begin();
    vsyn = 1'b0;
    #200;
  endtask

  task automatic frame_end();
    vsyn = 1'b1;
    #300;
  endtask

  initial begin
    logic [31:0] v;
    int toggles;
    int acks;
    logic prev;
    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_we_i = 1'b0;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_sel_i = 1'b1;

    repeat (4) @(posedge clk);
    #1;
    chk("rst_dat_o", wb.wb_dat_o, 32'd0);
    chk("rst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    chk("rst_outs", {29'd0, xclk, pwdn, creset}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    toggles = 0;
    prev = xclk;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (xclk !== prev) toggles++;
      prev = xclk;
    end
    chk("xclk_toggles", 32'(toggles), 32'd4);
    rd_chk(2'd1, 32'h0001_0000, "status_reset");

    wr(2'd2, 32'h10);
    chk("cam_reset_pin", {30'd0, pwdn, creset}, 32'd1);
    wr(2'd2, 32'h18);
    chk("cam_pwdn_pin", {30'd0, pwdn, creset}, 32'd3);
    rd_chk(2'd2, 32'h18, "ctrl_readback");
    wr(2'd2, 32'h10);

    rd_chk(2'd0, 32'd0, "data_empty");
    rd_chk(2'd1, 32'h0009_0000, "status_underflow");
    wr(2'd2, 32'h14);
    rd_chk(2'd1, 32'h0001_0000, "status_after_flush");

    wr(2'd2, 32'h11);
    rd_chk(2'd1, 32'h0021_0000, "status_armed");
    frame_begin();
    cam_line(8'h01, 8);
    cam_line(8'h09, 8);
    frame_end();
    rd_chk(2'd3, 32'd4, "count_single");
    rd_chk(2'd1, 32'h0010_0004, "status_single");
    rd_chk(2'd0, 32'h0403_0201, "data_w0");
    rd_chk(2'd0, 32'h0807_0605, "data_w1");
    rd_chk(2'd0, 32'h0C0B_0A09, "data_w2");
    rd_chk(2'd0, 32'h100F_0E0D, "data_w3");
    rd_chk(2'd1, 32'h0011_0000, "status_drained");

    wr(2'd2, 32'h11);
    frame_begin();
    cam_line(8'hA1, 6);
    frame_end();
    rd_chk(2'd3, 32'd2, "count_partial");
    rd_chk(2'd0, 32'hA4A3_A2A1, "partial_w0");
    rd_chk(2'd0, 32'h0000_A6A5, "partial_w1");

    wr(2'd2, 32'h11);
    frame_begin();
    cam_line(8'h00, 80);
    frame_end();
    rd_chk(2'd3, 32'd20, "count_overflow");
    rd_chk(2'd1, 32'h0016_0010, "status_overflow");
    for (int w = 0; w < 16; w++)
      rd_chk(2'd0, {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, "ovf_word");
    rd_chk(2'd1, 32'h0015_0000, "status_ovf_drained");
    wr(2'd2, 32'h14);
    rd_chk(2'd1, 32'h0011_0000, "status_ovf_flushed");

    wr(2'd2, 32'h13);
    frame_begin(); cam_line(8'h20, 4); frame_end();
    rd_chk(2'd1, 32'h0030_0001, "cont_frame1");
    frame_begin(); cam_line(8'h30, 4); frame_end();
    rd_chk(2'd1, 32'h0030_0002, "cont_frame2");
    frame_begin(); cam_line(8'h40, 4); frame_end();
    rd_chk(2'd1, 32'h0030_0003, "cont_frame3");
    wr(2'd2, 32'h10);
    rd_chk(2'd1, 32'h0030_0003, "cont_cleared_busy");
    frame_begin(); cam_line(8'h50, 4); frame_end();
    rd_chk(2'd1, 32'h0010_0004, "cont_idle");
    rd_chk(2'd3, 32'd1, "cont_count");
    rd_chk(2'd0, 32'h2322_2120, "cont_first_word");
    wr(2'd2, 32'h14);

    @(posedge clk); #1;
    wb.wb_adr_i = 32'h4; wb.wb_we_i = 1'b0; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb.wb_ack_o === 1'b1) acks++;
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    chk("held_stb_acks", 32'(acks), 32'd2);

    wr(2'd2, 32'h19);
    rd_chk(2'd1, 32'h0021_0000, "status_before_reset");
    frame_begin();
    href = 1'b1;
    #40;
    cam_byte(8'h71); cam_byte(8'h72); cam_byte(8'h73);
    #13 rst = 1'b0;
    #1;
    chk("midrst_dat_o", wb.wb_dat_o, 32'd0);
    chk("midrst_outs", {28'd0, wb.wb_ack_o, xclk, pwdn, creset}, 32'd0);
    href = 1'b0;
    vsyn = 1'b1;
    #300;
    @(posedge clk); #1 rst = 1'b1;
    rd_chk(2'd1, 32'h0001_0000, "status_after_midrst");
    rd_chk(2'd3, 32'd0, "count_after_midrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
